// File: rtl/nfsr_keystream_cipher.sv
// rtl/nfsr_keystream_cipher.sv - NFSR seed/warm-up controller and keystream byte cipher (optional NFSR_CIPHER_BYTE_CNT_EN)
module nfsr_keystream_cipher #(
  parameter int SEED_W = 24,
  parameter int DATA_W = 8,
  parameter int WARMUP = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              nfsr_ser_in,
  output logic              nfsr_par_load,
  output logic              nfsr_shift_en,
  output logic [SEED_W-1:0] nfsr_seed,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [DATA_W-1:0] cipher_out,
  output logic              cipher_valid,
  input  logic              cipher_ready,
  output logic              busy
`ifdef NFSR_CIPHER_BYTE_CNT_EN
  ,
  output logic [15:0]       byte_cnt
`endif
);

  // One counter serves both the warm-up run and the per-byte gather run.
  localparam int CNT_W = (WARMUP > DATA_W) ? $clog2(WARMUP + 1) : $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] GATH_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WARMUP    = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_GATHER    = 3'd4,
    S_OUTPUT    = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] ks;
  logic [DATA_W-1:0] data_latch;
  logic [DATA_W-1:0] ks_next;

  // Incoming keystream bit appended at the LSB so the first bit lands in the MSB.
  assign ks_next = {ks[DATA_W-2:0], nfsr_ser_in};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state decode and state-decoded NFSR/handshake controls.
  always_comb begin
    state_next    = state;
    nfsr_par_load = 1'b0;
    nfsr_shift_en = 1'b0;
    data_ready    = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        nfsr_par_load = 1'b1;
        if (WARMUP > 0) state_next = S_WARMUP;
        else            state_next = S_WAIT_DATA;
      end
      S_WARMUP: begin
        nfsr_shift_en = 1'b1;
        if (cnt == WARM_LAST) state_next = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        data_ready = 1'b1;
        if (data_valid) state_next = S_GATHER;
      end
      S_GATHER: begin
        nfsr_shift_en = 1'b1;
        if (cnt == GATH_LAST) state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (cipher_ready) state_next = S_WAIT_DATA;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Seed/data latches, keystream gathering, counter and registered cipher output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nfsr_seed    <= '0;
      cnt          <= '0;
      ks           <= '0;
      data_latch   <= '0;
      cipher_out   <= '0;
      cipher_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) nfsr_seed <= seed_in;
        end
        S_LOAD: cnt <= '0;
        S_WARMUP: cnt <= cnt + 1'b1;
        S_WAIT_DATA: begin
          if (data_valid) begin
            data_latch <= data_in;
            cnt        <= '0;
          end
        end
        S_GATHER: begin
          ks  <= ks_next;
          cnt <= cnt + 1'b1;
          if (cnt == GATH_LAST) begin
            cipher_out   <= data_latch ^ ks_next;
            cipher_valid <= 1'b1;
          end
        end
        S_OUTPUT: begin
          if (cipher_ready) cipher_valid <= 1'b0;
        end
        default: cnt <= '0;
      endcase
    end
  end

`ifdef NFSR_CIPHER_BYTE_CNT_EN
  // Count delivered cipher bytes, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                               byte_cnt <= '0;
    else if (state == S_OUTPUT && cipher_valid && cipher_ready) byte_cnt <= byte_cnt + 16'd1;
  end
`endif

endmodule
